// File: rtl/nibble_serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_subtractor_pkg
//  Brief    : Shared datapath definitions for the nibble-serial subtractor:
//             slice width, controller states and the status flag bundle.
//  Revision : 1.0  initial release
// ============================================================================
package nibble_serial_subtractor_pkg;

    // Width of one borrow-chain slice; operands are processed this many bits
    // per clock.
    localparam int c_NIBBLE_W = 4;

    // Controller states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Flag bundle in the order the status register consumes it.
    typedef struct packed {
        logic ovf;
        logic neg;
        logic zero;
        logic borrow_out;
    } flags_t;

    // Assemble the flag bundle from the individual flag terms.
    function automatic flags_t make_flags(input logic ovf, input logic neg,
                                          input logic zero, input logic borrow_out);
        flags_t f;
        f.ovf        = ovf;
        f.neg        = neg;
        f.zero       = zero;
        f.borrow_out = borrow_out;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/borrow_subtractor4.sv
`default_nettype none
// ============================================================================
//  Module   : borrow_subtractor4
//  Brief    : Combinational 4-bit ripple-borrow subtract slice,
//             d = x - y - bin, built from per-bit full subtractors.
//  Revision : 1.0  initial release
// ============================================================================
module borrow_subtractor4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    // w_borrow[i] is the borrow into bit i; w_borrow[4] leaves the slice.
    logic [4:0] w_borrow;

    assign w_borrow[0] = bin;

    // One full subtractor per bit: borrow when y + bin exceeds x at that bit.
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign d[i]          = x[i] ^ y[i] ^ w_borrow[i];
        assign w_borrow[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_borrow[i]);
    end

    assign bout = w_borrow[4];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_subtractor
//  Brief    : Multicycle A - B, one nibble per clock LSB first through a
//             single 4-bit borrow slice, with start/done handshake and
//             registered result and flags.
//  Revision : 1.0  initial release
// ============================================================================
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int c_NIBBLES = WIDTH / c_NIBBLE_W;
    localparam int c_IDX_W   = (c_NIBBLES > 1) ? $clog2(c_NIBBLES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NIBBLES - 1);

    if ((WIDTH % c_NIBBLE_W) != 0) begin : g_width_check
        $error("nibble_serial_subtractor: WIDTH must be a multiple of 4");
    end

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_borrow;
    logic [WIDTH-1:0]     r_diff;
    flags_t               r_flags;
    logic                 r_busy;
    logic                 r_done;

    logic [c_NIBBLE_W-1:0] w_a_nibs [c_NIBBLES];
    logic [c_NIBBLE_W-1:0] w_b_nibs [c_NIBBLES];
    logic [c_NIBBLE_W-1:0] w_d;
    logic                  w_bout;
    logic [WIDTH-1:0]      w_diff_next;
    logic                  w_last;
    logic                  w_ovf;

    // Split latched operands into nibbles and merge the fresh slice result
    // into the current nibble position of the running difference.
    for (genvar n = 0; n < c_NIBBLES; n++) begin : g_nib
        assign w_a_nibs[n] = r_a[n*c_NIBBLE_W +: c_NIBBLE_W];
        assign w_b_nibs[n] = r_b[n*c_NIBBLE_W +: c_NIBBLE_W];
        assign w_diff_next[n*c_NIBBLE_W +: c_NIBBLE_W] =
            (r_idx == c_IDX_W'(n)) ? w_d : r_diff[n*c_NIBBLE_W +: c_NIBBLE_W];
    end

    // The single shared slice, fed by the nibble selected by idx.
    borrow_subtractor4 u_slice (
        .x    (w_a_nibs[r_idx]),
        .y    (w_b_nibs[r_idx]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last = (r_idx == c_LAST_IDX);

    // Signed overflow uses the latched operand MSBs, not the live inputs.
    assign w_ovf = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_diff_next[WIDTH-1] ^ r_a[WIDTH-1]);

    // Controller and datapath: accept in IDLE, one nibble per edge in RUN,
    // flags and done on the final nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
            r_flags  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= 1'b0;
                        r_idx    <= '0;
                        r_diff   <= '0;
                        r_flags  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_diff   <= w_diff_next;
                    r_borrow <= w_bout;
                    if (w_last) begin
                        r_flags <= make_flags(w_ovf, w_diff_next[WIDTH-1],
                                              ~|w_diff_next, w_bout);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_flags.borrow_out;
    assign zero       = r_flags.zero;
    assign neg        = r_flags.neg;
    assign ovf        = r_flags.ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_serial_subtractor
//  Brief    : Scoreboard bench for nibble_serial_subtractor: directed cases
//             plus randomized operations against an arithmetic reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nibble_serial_subtractor;

    typedef struct packed {
        logic [15:0] diff;
        logic        ovf;
        logic        neg;
        logic        zero;
        logic        bout;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        borrow_out;
    logic        zero;
    logic        neg;
    logic        ovf;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero),
        .neg        (neg),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int ux, uy, sx, sy, sd;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        sd = sx - sy;
        e.diff = 16'((ux - uy + 65536) % 65536);
        e.bout = (ux < uy);
        e.zero = (e.diff == 16'd0);
        e.neg  = (e.diff >= 16'h8000);
        e.ovf  = (sd > 32767) || (sd < -32768);
        return e;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 16'd1, 16'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("diff", diff, e.diff);
                chk("flags{ovf,neg,zero,borrow}", {12'd0, ovf, neg, zero, borrow_out},
                    {12'd0, e.ovf, e.neg, e.zero, e.bout});
            end
        end
    end

    // Call at a negedge while idle: present operands, accept on next edge.
    task automatic launch(input logic [15:0] x, input logic [15:0] y);
        start = 1'b1;
        a     = x;
        b     = y;
        exp_q.push_back(model(x, y));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Checks busy/done per cycle; optionally pokes start and new operands
    // during RUN, which the DUT must ignore. Returns at the done negedge.
    task automatic expect_timing(input bit poke);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy_during_run", {14'd0, busy, done}, 16'h0002);
            if (poke) begin
                start = 1'b1;
                a     = 16'($urandom);
                b     = 16'($urandom);
            end
        end
        @(negedge clk);
        chk("done_cycle_busy_done", {14'd0, busy, done}, 16'h0001);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {8'd0, 3'd0, busy, done, borrow_out, zero, neg}, 16'd0);
        chk({name, "_diff_ovf"}, diff | {15'd0, ovf}, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t hold_e;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic operation, then verify outputs hold while idle.
        launch(16'h1234, 16'h0234);
        expect_timing(1'b0);
        hold_e = model(16'h1234, 16'h0234);
        repeat (3) @(negedge clk);
        chk("hold_diff", diff, hold_e.diff);
        chk("hold_busy_done", {14'd0, busy, done}, 16'd0);

        // Full borrow ripple and the two overflow corners.
        launch(16'h0000, 16'h0001); expect_timing(1'b0);
        launch(16'h8000, 16'h0001); expect_timing(1'b0);
        launch(16'h7FFF, 16'hFFFF); expect_timing(1'b0);

        // Zero result followed by a start in the done cycle.
        launch(16'h5A5A, 16'h5A5A); expect_timing(1'b0);
        launch(16'h0010, 16'h0001); expect_timing(1'b0);

        // Start and operand changes while busy are ignored.
        @(negedge clk);
        launch(16'h1234, 16'h0234); expect_timing(1'b1);

        // Reset after nibble 2 discards the operation.
        @(negedge clk);
        launch(16'h1234, 16'h0234);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_run_reset");
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("no_done_in_reset", {15'd0, done}, 16'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        launch(16'hFFFF, 16'h0001); expect_timing(1'b0);

        // Randomized operations, mixing back-to-back and gapped starts.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) @(negedge clk);
            launch(16'($urandom), 16'($urandom));
            expect_timing($urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
